// File: rtl/rbm_sample_sched.sv
// rbm_sample_sched: RBM Gibbs-sampling run sequencer with decimating sample FIFO; RBM_MATCH_COUNT_EN adds a pattern match counter
module rbm_sample_sched #(
  parameter int NUM_VNODES = 3,
  parameter int CNT_W      = 32,
  parameter int INT_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [CNT_W-1:0]      burn_in,
  input  logic [INT_W-1:0]      interval,
  input  logic [CNT_W-1:0]      num_samples,
  output logic                  rbm_reset,
  output logic                  rbm_stall,
  input  logic [NUM_VNODES-1:0] rbm_node_data,
  output logic [NUM_VNODES-1:0] sample_data,
  output logic                  sample_valid,
  input  logic                  sample_ready,
  output logic                  busy,
  output logic                  done
`ifdef RBM_MATCH_COUNT_EN
  ,
  input  logic [NUM_VNODES-1:0] match_pattern,
  input  logic [NUM_VNODES-1:0] match_mask,
  output logic [CNT_W-1:0]      match_count
`endif
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  typedef enum logic [2:0] {IDLE, INIT, BURN, RUN, DRAIN} state_t;
  state_t state;
  logic adv_q, init_cnt, push, pop, last;
  logic [CNT_W-1:0] burn_q, num_q, burn_cnt, smp_cnt;
  logic [INT_W-1:0] ivl_q, int_cnt;
  logic [NUM_VNODES-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level, level_nxt;
  assign push = state == RUN && adv_q && int_cnt + INT_W'(1) == ivl_q;
  assign pop = sample_valid && sample_ready;
  assign last = push && smp_cnt + CNT_W'(1) == num_q;
  assign level_nxt = level + LW'(push) - LW'(pop);
  assign sample_valid = level != '0;
  assign sample_data = mem[rd_ptr];
  assign busy = state != IDLE;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= rbm_node_data;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      rbm_reset <= 1'b1;
      rbm_stall <= 1'b1;
      done <= 1'b0;
      adv_q <= 1'b0;
      init_cnt <= 1'b0;
      burn_q <= '0;
      num_q <= '0;
      ivl_q <= '0;
      burn_cnt <= '0;
      smp_cnt <= '0;
      int_cnt <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
    end else begin
      adv_q <= !rbm_stall && !rbm_reset;
      done <= 1'b0;
      wr_ptr <= push ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr <= pop ? rd_ptr + AW'(1) : rd_ptr;
      level <= level_nxt;
      if (abort) begin
        state <= IDLE;
        rbm_reset <= 1'b1;
        rbm_stall <= 1'b1;
        wr_ptr <= '0;
        rd_ptr <= '0;
        level <= '0;
      end else
        case (state)
          IDLE: if (start) begin
            state <= INIT;
            init_cnt <= 1'b0;
            burn_q <= burn_in;
            num_q <= num_samples;
            ivl_q <= interval == '0 ? INT_W'(1) : interval;
            burn_cnt <= '0;
            smp_cnt <= '0;
            int_cnt <= '0;
          end
          INIT: begin
            init_cnt <= 1'b1;
            if (init_cnt) begin
              rbm_reset <= 1'b0;
              rbm_stall <= num_q == '0;
              state <= num_q == '0 ? DRAIN : burn_q == '0 ? RUN : BURN;
            end
          end
          BURN: if (adv_q) begin
            burn_cnt <= burn_cnt + CNT_W'(1);
            if (burn_cnt + CNT_W'(1) == burn_q) state <= RUN;
          end
          RUN: begin
            if (adv_q) int_cnt <= push ? '0 : int_cnt + INT_W'(1);
            if (push) smp_cnt <= smp_cnt + CNT_W'(1);
            // one update may still be in flight after stall rises, so stall one entry early
            rbm_stall <= last || level_nxt >= LW'(FIFO_DEPTH - 1);
            if (last) state <= DRAIN;
          end
          DRAIN: if (level_nxt == '0) begin
            state <= IDLE;
            rbm_reset <= 1'b1;
            done <= 1'b1;
          end
          default: state <= IDLE;
        endcase
    end
`ifdef RBM_MATCH_COUNT_EN
  logic [NUM_VNODES-1:0] pat_q, mask_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      pat_q <= '0;
      mask_q <= '0;
      match_count <= '0;
    end else if (state == IDLE && start && !abort) begin
      pat_q <= match_pattern;
      mask_q <= match_mask;
      match_count <= '0;
    end else if (push && ((rbm_node_data ^ pat_q) & mask_q) == '0 && match_count != '1)
      match_count <= match_count + CNT_W'(1);
`endif
endmodule

// File: tb/tb_rbm_sample_sched.sv
// tb_rbm_sample_sched: directed bench driving a counter-model RBM core into rbm_sample_sched
module tb_rbm_sample_sched;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, abort = 1'b0, sample_ready = 1'b1;
  logic [31:0] burn_in = '0, num_samples = '0;
  logic [15:0] interval = '0;
  logic rbm_reset, rbm_stall, sample_valid, busy, done;
  logic [2:0] core, sample_data;
  int total = 0, bad = 0, dones, stall0, n;
  logic [2:0] got[$];
  int when[$];
  logic [2:0] e1 [4] = '{3'd0, 3'd3, 3'd6, 3'd1};
`ifdef RBM_MATCH_COUNT_EN
  logic [2:0] match_pattern = '0, match_mask = '0;
  logic [31:0] match_count;
`endif
  always #5 clk = ~clk;
  always_ff @(posedge clk or posedge reset)
    if (reset || rbm_reset) core <= '0;
    else if (!rbm_stall) core <= core + 3'd1;
  rbm_sample_sched dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .burn_in(burn_in),
    .interval(interval), .num_samples(num_samples), .rbm_reset(rbm_reset),
    .rbm_stall(rbm_stall), .rbm_node_data(core), .sample_data(sample_data),
    .sample_valid(sample_valid), .sample_ready(sample_ready), .busy(busy), .done(done)
`ifdef RBM_MATCH_COUNT_EN
    , .match_pattern(match_pattern), .match_mask(match_mask), .match_count(match_count)
`endif
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic go(input int b, input int iv, input int ns);
    burn_in = b;
    interval = iv[15:0];
    num_samples = ns;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask
  task automatic reset_cycles(output int c);
    c = 0;
    while (rbm_reset && c < 10) begin
      c++;
      step();
    end
  endtask
  task automatic collect(input string tag, input int budget);
    int i;
    got.delete();
    when.delete();
    dones = 0;
    stall0 = 0;
    for (i = 0; i < budget; i++) begin
      if (sample_valid && sample_ready) begin
        got.push_back(sample_data);
        when.push_back(i);
      end
      if (done) dones++;
      if (!rbm_stall) stall0++;
      if (!busy && dones > 0) break;
      step();
    end
    chk({tag, "_in_time"}, 32'(i < budget), 1);
  endtask
  task automatic check_run1(input string tag);
    collect(tag, 300);
    chk({tag, "_count"}, got.size(), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("%s_s%0d", tag, i), 32'(got[i]), 32'(e1[i]));
    chk({tag, "_dones"}, dones, 1);
    chk({tag, "_busy"}, 32'(busy), 0);
    step();
    chk({tag, "_done_pulse"}, 32'(done), 0);
  endtask
  initial begin
    step();
    chk("rst_rbm_reset", 32'(rbm_reset), 1);
    chk("rst_stall", 32'(rbm_stall), 1);
    chk("rst_valid", 32'(sample_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    reset = 1'b0;
    step();
    abort = 1'b1;
    start = 1'b1;
    step();
    abort = 1'b0;
    start = 1'b0;
    chk("abort_over_start", 32'(busy), 0);
    // basic run: burn 5, keep every 3rd, 4 samples
    go(5, 3, 4);
    chk("t1_busy", 32'(busy), 1);
    reset_cycles(n);
    chk("t1_reset_cycles", n, 2);
    check_run1("t1");
    // backpressure: host not ready, config changed and start pulsed mid-run
    sample_ready = 1'b0;
    go(5, 3, 4);
    repeat (60) step();
    chk("t2_stall_held", 32'(rbm_stall), 1);
    chk("t2_busy", 32'(busy), 1);
    chk("t2_done", 32'(done), 0);
    chk("t2_head", 32'(sample_data), 0);
    burn_in = 1;
    interval = 1;
    num_samples = 9;
    start = 1'b1;
    step();
    start = 1'b0;
    sample_ready = 1'b1;
    check_run1("t2");
    // zero samples: INIT then DRAIN then IDLE with done
    go(5, 3, 0);
    reset_cycles(n);
    chk("t3_reset_cycles", n, 2);
    chk("t3_drain_busy", 32'(busy), 1);
    chk("t3_drain_stall", 32'(rbm_stall), 1);
    step();
    chk("t3_done", 32'(done), 1);
    chk("t3_idle", 32'(busy), 0);
    chk("t3_valid", 32'(sample_valid), 0);
    step();
    chk("t3_done_pulse", 32'(done), 0);
    // interval 0 acts as 1, no burn-in
    go(0, 0, 3);
    collect("t4", 100);
    chk("t4_count", got.size(), 3);
    for (int i = 0; i < 3; i++) chk($sformatf("t4_s%0d", i), 32'(got[i]), i + 1);
    chk("t4_consec_a", when[1] - when[0], 1);
    chk("t4_consec_b", when[2] - when[1], 1);
    chk("t4_dones", dones, 1);
    // abort with samples queued
    sample_ready = 1'b0;
    go(0, 1, 10);
    n = 0;
    while (!sample_valid && n < 20) begin
      n++;
      step();
    end
    chk("t5_valid_seen", 32'(sample_valid), 1);
    step();
    abort = 1'b1;
    start = 1'b1;
    step();
    abort = 1'b0;
    start = 1'b0;
    chk("t5_busy", 32'(busy), 0);
    chk("t5_valid", 32'(sample_valid), 0);
    chk("t5_stall", 32'(rbm_stall), 1);
    chk("t5_rbm_reset", 32'(rbm_reset), 1);
    n = 0;
    repeat (4) begin
      if (done) n++;
      step();
    end
    chk("t5_no_done", n, 0);
    sample_ready = 1'b1;
    go(5, 3, 4);
    check_run1("t5r");
`ifdef RBM_MATCH_COUNT_EN
    match_pattern = 3'b001;
    match_mask = 3'b101;
    go(0, 1, 7);
    chk("t6_cleared", match_count, 0);
    collect("t6", 100);
    chk("t6_count", got.size(), 7);
    chk("t6_matches", match_count, 2);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
